req_encoder_16x4: RTL and testbench

Sequential 16-to-4 request encoder. It is the encode-side counterpart of the team's 4-to-16 one-hot decoder: index `i` here corresponds to decoder output `1 << i`. It collects one-hot or multi-hot request pulses into a pending register. It then emits their 4-bit indices one at a time, lowest index first, over a valid/ready handshake. It sits between request-generating logic (one-hot strobes) and any consumer that needs a binary index stream.

---
 rtl/req_encoder_16x4.sv | 135 +++++++++++++
 tb/tb_req_encoder_16x4.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder_16x4.sv
// req_encoder_16x4
// Sequential 16-to-4 request encoder. Request pulses (one-hot or multi-hot)
// are merged into a pending register; pending indices are emitted one at a
// time, lowest index first, through a registered valid/ready output stage.
// A sticky overflow flag records any request that hit an index that was
// already pending and not being handed out in the same cycle.
// clr acts as the synchronous soft reset of all state.

module req_encoder_16x4 #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    // Index of the lowest set bit; bit 0 has the highest priority.
    // Scanning downward lets the last hit (the lowest index) win.
    function automatic logic [IDX_W-1:0] lowest_index(input logic [N-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot mask for a given index (decoder direction).
    function automatic logic [N-1:0] index_mask(input logic [IDX_W-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Architectural state
    logic [N-1:0]     pend_r;
    logic             ov_r;
    logic [IDX_W-1:0] oidx_r;
    logic             ovf_r;

    // Next-state helpers
    logic             fire_s;
    logic             load_s;
    logic [IDX_W-1:0] sel_s;
    logic [N-1:0]     lmask_s;
    logic [N-1:0]     req_in_s;
    logic [N-1:0]     pend_nxt_s;
    logic             dup_s;

    // Handshake, selection and next pending value.
    // Only bits already in pend_r can be loaded, so a request arriving this
    // cycle is never handed out in the same cycle.
    always_comb begin
        fire_s     = 1'b0;
        load_s     = 1'b0;
        sel_s      = {IDX_W{1'b0}};
        lmask_s    = {N{1'b0}};
        req_in_s   = {N{1'b0}};
        pend_nxt_s = pend_r;
        dup_s      = 1'b0;

        fire_s = ov_r & out_ready;
        sel_s  = lowest_index(pend_r);
        load_s = (~ov_r | fire_s) & (|pend_r);

        if (load_s) begin
            lmask_s = index_mask(sel_s);
        end else begin
            lmask_s = {N{1'b0}};
        end

        if (en) begin
            req_in_s = req;
        end else begin
            req_in_s = {N{1'b0}};
        end

        // A bit being loaded now and requested again re-sets as a fresh
        // request; only bits that stay pending count as duplicates.
        pend_nxt_s = (pend_r & ~lmask_s) | req_in_s;
        dup_s      = |(req_in_s & pend_r & ~lmask_s);
    end

    // State update: async reset, then clr, then normal operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= {N{1'b0}};
            ov_r   <= 1'b0;
            oidx_r <= {IDX_W{1'b0}};
            ovf_r  <= 1'b0;
        end else if (clr) begin
            pend_r <= {N{1'b0}};
            ov_r   <= 1'b0;
            oidx_r <= {IDX_W{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;

            if (load_s) begin
                ov_r   <= 1'b1;
                oidx_r <= sel_s;
            end else if (fire_s) begin
                ov_r   <= 1'b0;
                oidx_r <= oidx_r;
            end else begin
                ov_r   <= ov_r;
                oidx_r <= oidx_r;
            end

            if (dup_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign out_valid = ov_r;
    assign out_idx   = oidx_r;
    assign pending   = pend_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_req_encoder_16x4.sv
// Self-checking bench for req_encoder_16x4: a cycle-level reference model of
// the encoder's rules, compared against the DUT on every falling edge, plus
// directed scenarios with hand-computed expectations.

module tb_req_encoder_16x4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [15:0] req;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic [15:0] pending;
    logic        overflow;

    int vectors;
    int miscompares;

    req_encoder_16x4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending set as an array of flags, output slot, sticky flag
    bit m_pend [16];
    bit m_ov;
    int m_idx;
    bit m_ovf;

    function automatic logic [15:0] model_pending();
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < 16; i++) if (m_pend[i]) v = v + (16'(1) << i);
        return v;
    endfunction

    // Model update on each clock edge (and asynchronous reset)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
            m_ov = 1'b0; m_idx = 0; m_ovf = 1'b0;
        end else begin
            int granted;
            bit accepted;
            granted  = -1;
            accepted = m_ov && out_ready;
            if (!m_ov || accepted) begin
                for (int i = 0; i < 16; i++) begin
                    if (m_pend[i]) begin
                        granted = i;
                        break;
                    end
                end
            end
            for (int i = 0; i < 16; i++) begin
                bit incoming;
                incoming = en && req[i];
                if (incoming && m_pend[i] && i != granted) m_ovf = 1'b1;
                if (i == granted) m_pend[i] = 1'b0;
                if (incoming) m_pend[i] = 1'b1;
            end
            if (granted >= 0) begin
                m_ov = 1'b1; m_idx = granted;
            end else if (accepted) begin
                m_ov = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        check("model.out_valid", int'(out_valid), int'(m_ov));
        if (m_ov) check("model.out_idx", int'(out_idx), m_idx);
        check("model.pending", int'(pending), int'(model_pending()));
        check("model.overflow", int'(overflow), int'(m_ovf));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input bit v, input int idx,
                              input int pend, input bit ovf);
        check({name, ".valid"}, int'(out_valid), int'(v));
        if (v) check({name, ".idx"}, int'(out_idx), idx);
        check({name, ".pending"}, int'(pending), pend);
        check({name, ".overflow"}, int'(overflow), int'(ovf));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; req = 16'h0000; out_ready = 1'b0;
        step(2);
        expect_out("reset_init", 1'b0, 0, 16'h0000, 1'b0);
        check("reset_init.idx0", int'(out_idx), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        step(1);

        // Asynchronous reset mid-transfer
        req = 16'h0001; step(1);
        req = 16'h00F0; step(1);
        req = 16'h0000;
        expect_out("pre_reset", 1'b1, 0, 16'h00F0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, 0, 16'h0000, 1'b0);
        check("async_reset.idx0", int'(out_idx), 0);
        #1 rst_n = 1'b1;
        step(3);
        expect_out("post_reset_idle", 1'b0, 0, 16'h0000, 1'b0);

        // Single request: index 5 visible two cycles later, for one cycle
        out_ready = 1'b1;
        req = 16'h0020; step(1);
        req = 16'h0000;
        expect_out("single.c1", 1'b0, 0, 16'h0020, 1'b0);
        step(1);
        expect_out("single.c2", 1'b1, 5, 16'h0000, 1'b0);
        step(1);
        expect_out("single.c3", 1'b0, 0, 16'h0000, 1'b0);

        // Ordering: 0, 5, 10, 15 back to back
        req = 16'h8421; step(1);
        req = 16'h0000;
        expect_out("order.c1", 1'b0, 0, 16'h8421, 1'b0);
        step(1); expect_out("order.i0", 1'b1, 0,  16'h8420, 1'b0);
        step(1); expect_out("order.i5", 1'b1, 5,  16'h8400, 1'b0);
        step(1); expect_out("order.i10", 1'b1, 10, 16'h8000, 1'b0);
        step(1); expect_out("order.i15", 1'b1, 15, 16'h0000, 1'b0);
        step(1); expect_out("order.done", 1'b0, 0, 16'h0000, 1'b0);

        // Backpressure, plus a re-request of the index held in the output stage
        out_ready = 1'b0;
        req = 16'h0003; step(1);
        req = 16'h0000;
        expect_out("bp.c1", 1'b0, 0, 16'h0003, 1'b0);
        step(1); expect_out("bp.hold1", 1'b1, 0, 16'h0002, 1'b0);
        step(1); expect_out("bp.hold2", 1'b1, 0, 16'h0002, 1'b0);
        req = 16'h0001; step(1);
        req = 16'h0000;
        expect_out("bp.rereq_held", 1'b1, 0, 16'h0003, 1'b0);
        out_ready = 1'b1;
        step(1); expect_out("bp.acc0", 1'b1, 0, 16'h0002, 1'b0);
        step(1); expect_out("bp.acc1", 1'b1, 1, 16'h0000, 1'b0);
        step(1); expect_out("bp.drain", 1'b0, 0, 16'h0000, 1'b0);

        // Overflow, en=0 ignore, and clr with simultaneous requests
        out_ready = 1'b0;
        req = 16'h0009; step(1);
        req = 16'h0000; step(1);
        expect_out("ovf.setup", 1'b1, 0, 16'h0008, 1'b0);
        req = 16'h0008; step(1);
        req = 16'h0000;
        expect_out("ovf.dup", 1'b1, 0, 16'h0008, 1'b1);
        en = 1'b0; req = 16'hFFFF; step(1);
        expect_out("ovf.en0", 1'b1, 0, 16'h0008, 1'b1);
        en = 1'b1; clr = 1'b1; step(1);
        clr = 1'b0; req = 16'h0000;
        expect_out("clr", 1'b0, 0, 16'h0000, 1'b0);
        check("clr.idx0", int'(out_idx), 0);
        step(1);

        // Full pending, then a further duplicate only raises overflow
        req = 16'hFFFF; step(1);
        req = 16'h0000; step(1);
        expect_out("full.load", 1'b1, 0, 16'hFFFE, 1'b0);
        req = 16'h0001; step(1);
        req = 16'h0000;
        expect_out("full.rereq0", 1'b1, 0, 16'hFFFF, 1'b0);
        req = 16'h8000; step(1);
        req = 16'h0000;
        expect_out("full.dup", 1'b1, 0, 16'hFFFF, 1'b1);
        out_ready = 1'b1;
        step(17);
        expect_out("full.drained", 1'b0, 0, 16'h0000, 1'b1);
        clr = 1'b1; step(1); clr = 1'b0;

        // Round trip through every decoder output
        for (int i = 0; i < 16; i++) begin
            logic [15:0] one;
            one = 16'h0001;
            req = one << i; step(1);
            req = 16'h0000; step(1);
            expect_out($sformatf("rt.%0d", i), 1'b1, i, 16'h0000, 1'b0);
        end
        step(2);
        expect_out("rt.end", 1'b0, 0, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
